gpu_cmd_tx: RTL and testbench
=============================

# gpu_cmd_tx

Host-side transmitter for the GPU command interface. Accepts commands (store byte, move cursor, display/swap, clear) from the CPU/bus side through a valid/ready handshake and buffers them in a small FIFO. Serialises each command onto the GPU's `interrupt_in` / `data_in` / `interrupt_enable` lines with guaranteed setup, strobe and gap timing. The GPU latches on the rising edge of `interrupt_enable`, so op and data are held stable across every edge.

## Interface
- `DEPTH`, 4: command FIFO depth, power of two, ≥2.
- `SETUP_CYCLES`, 1: cycles op/data are stable before `interrupt_enable` rises, ≥1.
- `STROBE_CYCLES`, 2: cycles `interrupt_enable` is high, ≥1.
- `GAP_CYCLES`, 1: cycles `interrupt_enable` is low after strobe, with op/data still held, ≥1.

Ports:
- `clk` in 1: system clock; one clock domain, all logic on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: host command present.
- `cmd_ready` out 1: FIFO not full.
- `cmd_op` in 2: 00 STORE_BYTE, 01 MOVE_CURSOR, 10 DISPLAY, 11 CLEAR.
- `cmd_data` in 8: payload.
- `interrupt_in` out 2: op to GPU, registered.
- `data_out` out 8: payload to GPU `data_in`, registered.
- `interrupt_enable` out 1: strobe to GPU, registered.
- `busy` out 1: FSM not IDLE or FIFO non-empty.
- `fifo_level` out $clog2(DEPTH)+1: entries held.
- `cursor_x` out 7, `cursor_y` out 6: shadow cursor. Present only with `GPU_TX_CURSOR_SHADOW_EN`.

## Operation
- FIFO of {op, data}, DEPTH entries, with an extra-bit pointer full/empty scheme.
- Push on `cmd_valid & cmd_ready`. `cmd_ready = !full` and does not look ahead at a same-cycle pop. When full, a same-cycle push is rejected even if a pop occurs.
- FSM states and transitions:
  - IDLE: when the FIFO is non-empty, pop the head, register it onto `interrupt_in` / `data_out`, load the counter with SETUP_CYCLES, and go to SETUP.
  - SETUP: count down. At terminal count, set `interrupt_enable` = 1 and go to STROBE.
  - STROBE: count STROBE_CYCLES. Then set `interrupt_enable` = 0 and go to GAP.
  - GAP: count GAP_CYCLES, then go to IDLE.
- `interrupt_in` / `data_out` change only on the IDLE→SETUP edge and otherwise hold their last value, including while idle.
- Commands are emitted strictly in acceptance order. No payload interpretation or filtering is done; all four ops are transmitted identically.
- Counter width is $clog2(max(SETUP,STROBE,GAP)+1).
- Reset value of every output:
  - `interrupt_in` = 0, `data_out` = 0, `interrupt_enable` = 0.
  - `busy` = 0, `fifo_level` = 0, `cmd_ready` = 1.
  - `cursor_x` = 0, `cursor_y` = 0.
- Reset mid-operation: FSM is forced to IDLE, the FIFO is flushed, and `interrupt_enable` drops immediately (asynchronous). The command in flight is lost.

## Timing
- Accept at edge N with the FIFO empty and FSM in IDLE:
  - Bus loaded at edge N+1.
  - `interrupt_enable` high from edge N+1+SETUP to edge N+1+SETUP+STROBE.
  - FSM returns to IDLE at edge N+1+SETUP+STROBE+GAP.
- Back-to-back throughput is one command per 1+SETUP+STROBE+GAP cycles; defaults give 5.
- `fifo_level` and `cmd_ready` update on the edge after a push or pop. A simultaneous push and pop (not full) leaves the level unchanged.

## Configuration
- `GPU_TX_CURSOR_SHADOW_EN` defined: `cursor_x` / `cursor_y` track the GPU cursor, updated when a command is popped.
  - STORE_BYTE: x+1. If x was 79, x=0 and y=(y+1) mod 60.
  - MOVE_CURSOR with data[7]=1: x=(x+data[6:0]) mod 80.
  - MOVE_CURSOR with data[7]=0: y=(y+data[5:0]) mod 60.
  - DISPLAY and CLEAR: no effect.
- `GPU_TX_CURSOR_SHADOW_EN` undefined: ports and tracking logic are absent; all other behaviour is identical.

## Test plan
- Reset: assert `rst_n`=0 mid-stream → all outputs are at their reset values within the same cycle, `cmd_ready`=1, and no further strobe occurs after release.
- Single STORE 0x41 accepted at edge N (defaults) → `interrupt_in`=00 and `data_out`=0x41 at N+1; `interrupt_enable` high for edges N+2..N+3 and low at N+4; `busy`=0 after N+5.
- Six commands offered on consecutive cycles (DEPTH=4) → `cmd_ready` drops once 4 are held, and all six are emitted in order with `interrupt_enable` rising every 5 cycles.
- Reset asserted during STROBE of a DISPLAY command → `interrupt_enable`=0 immediately, `fifo_level`=0, and the FSM idles after release.
- Op coverage: MOVE 0x85, DISPLAY 0x00, CLEAR 0xFF → op/data are stable from SETUP through GAP for each, and each is strobed exactly once.
- With `GPU_TX_CURSOR_SHADOW_EN`:
  - 80 STOREs from (0,0) → (0,1).
  - Then MOVE 0x80|78, then MOVE 0x85 → x=3.
  - MOVE 0x3B from y=1 → y=0.

Source files
------------

// File: rtl/gpu_cmd_tx.sv
// gpu_cmd_tx: buffers host commands in a FIFO and serialises them onto the GPU
// interrupt bus with setup/strobe/gap timing. Optional macro: GPU_TX_CURSOR_SHADOW_EN.
module gpu_cmd_tx #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [7:0]               cmd_data,
  output logic [1:0]               interrupt_in,
  output logic [7:0]               data_out,
  output logic                     interrupt_enable,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef GPU_TX_CURSOR_SHADOW_EN
  ,
  output logic [6:0]               cursor_x,
  output logic [5:0]               cursor_y
`endif
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned MAXC = (SETUP_CYCLES > STROBE_CYCLES)
                                 ? ((SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES)
                                 : ((STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES);
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  cmd_t          r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_ie;
  logic          w_ie_nxt;
  logic [1:0]    r_op;
  logic [7:0]    r_data;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  cmd_t          w_head;

  // Extra-bit pointers: equal means empty, MSB-only difference means full
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = cmd_valid && !w_full;
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  assign cmd_ready        = !w_full;
  assign fifo_level       = r_wptr - r_rptr;
  assign busy             = (r_state != ST_IDLE) || !w_empty;
  assign interrupt_in     = r_op;
  assign data_out         = r_data;
  assign interrupt_enable = r_ie;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= cmd_t'{op: cmd_op, data: cmd_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Sequencer next state: each timed phase reloads the counter and ends at count 1
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ie_nxt    = r_ie;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_cnt_nxt   = CW'(SETUP_CYCLES);
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == CW'(1)) begin
          w_ie_nxt    = 1'b1;
          w_cnt_nxt   = CW'(STROBE_CYCLES);
          w_state_nxt = ST_STROBE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_STROBE: begin
        if (r_cnt == CW'(1)) begin
          w_ie_nxt    = 1'b0;
          w_cnt_nxt   = CW'(GAP_CYCLES);
          w_state_nxt = ST_GAP;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt == CW'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_ie_nxt    = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ie    <= 1'b0;
      r_op    <= 2'b00;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ie    <= w_ie_nxt;
      if (w_pop) begin
        r_op   <= w_head.op;
        r_data <= w_head.data;
      end
    end
  end

`ifdef GPU_TX_CURSOR_SHADOW_EN
  logic [6:0] r_cx;
  logic [5:0] r_cy;
  logic [6:0] w_cx_nxt;
  logic [5:0] w_cy_nxt;
  logic [7:0] w_xsum;
  logic [6:0] w_ysum;

  assign w_xsum = {1'b0, r_cx} + {1'b0, w_head.data[6:0]};
  assign w_ysum = {1'b0, r_cy} + {1'b0, w_head.data[5:0]};

  // Cursor mirror of the GPU's 80x60 text grid, advanced as each command is popped
  always_comb begin
    w_cx_nxt = r_cx;
    w_cy_nxt = r_cy;
    case (w_head.op)
      2'b00: begin
        if (r_cx == 7'd79) begin
          w_cx_nxt = 7'd0;
          w_cy_nxt = (r_cy == 6'd59) ? 6'd0 : r_cy + 6'd1;
        end else begin
          w_cx_nxt = r_cx + 7'd1;
        end
      end
      2'b01: begin
        if (w_head.data[7]) begin
          if (w_xsum >= 8'd160)     w_cx_nxt = 7'(w_xsum - 8'd160);
          else if (w_xsum >= 8'd80) w_cx_nxt = 7'(w_xsum - 8'd80);
          else                      w_cx_nxt = 7'(w_xsum);
        end else begin
          if (w_ysum >= 7'd120)     w_cy_nxt = 6'(w_ysum - 7'd120);
          else if (w_ysum >= 7'd60) w_cy_nxt = 6'(w_ysum - 7'd60);
          else                      w_cy_nxt = 6'(w_ysum);
        end
      end
      default: begin
        w_cx_nxt = r_cx;
        w_cy_nxt = r_cy;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cx <= 7'd0;
      r_cy <= 6'd0;
    end else if (w_pop) begin
      r_cx <= w_cx_nxt;
      r_cy <= w_cy_nxt;
    end
  end

  assign cursor_x = r_cx;
  assign cursor_y = r_cy;
`endif

endmodule

// File: tb/tb_gpu_cmd_tx.sv
// tb_gpu_cmd_tx: directed + randomized stimulus against a cycle-level occupancy/timing
// reference model, with an in-order scoreboard checked on every strobe rising edge.
`timescale 1ns/1ps
module tb_gpu_cmd_tx;

  localparam int DEPTH  = 4;
  localparam int SETUP  = 1;
  localparam int STROBE = 2;
  localparam int GAP    = 1;
  localparam int PERIOD = 1 + SETUP + STROBE + GAP;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op    = 2'b00;
  logic [7:0] cmd_data  = 8'h00;
  logic       cmd_ready;
  logic [1:0] interrupt_in;
  logic [7:0] data_out;
  logic       interrupt_enable;
  logic       busy;
  logic [$clog2(DEPTH):0] fifo_level;
`ifdef GPU_TX_CURSOR_SHADOW_EN
  logic [6:0] cursor_x;
  logic [5:0] cursor_y;
`endif

  gpu_cmd_tx #(
    .DEPTH(DEPTH), .SETUP_CYCLES(SETUP), .STROBE_CYCLES(STROBE), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .interrupt_in(interrupt_in),
    .data_out(data_out), .interrupt_enable(interrupt_enable), .busy(busy),
    .fifo_level(fifo_level)
`ifdef GPU_TX_CURSOR_SHADOW_EN
    , .cursor_x(cursor_x), .cursor_y(cursor_y)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: queue occupancy plus the edge index of the last launch
  logic [9:0] mq[$];
  logic [9:0] expq[$];
  int         k        = 0;
  int         last_pop = -100;
  logic [1:0] m_op     = 2'b00;
  logic [7:0] m_data   = 8'h00;
  int         m_cx     = 0;
  int         m_cy     = 0;

  function automatic bit model_ie();
    return (k >= last_pop + SETUP) && (k < last_pop + SETUP + STROBE);
  endfunction

  function automatic bit model_busy();
    return (mq.size() > 0) || (k < last_pop + SETUP + STROBE + GAP);
  endfunction

  always @(posedge clk) begin
    bit         full;
    bit         pop;
    logic [9:0] c;
    if (rst_n) begin
      k++;
      full = (mq.size() == DEPTH);
      pop  = (mq.size() > 0) && (k >= last_pop + PERIOD);
      if (pop) begin
        c        = mq.pop_front();
        m_op     = c[9:8];
        m_data   = c[7:0];
        last_pop = k;
        if (c[9:8] == 2'b00) begin
          if (m_cx == 79) begin
            m_cx = 0;
            m_cy = (m_cy + 1) % 60;
          end else begin
            m_cx = m_cx + 1;
          end
        end else if (c[9:8] == 2'b01) begin
          if (c[7]) m_cx = (m_cx + int'(c[6:0])) % 80;
          else      m_cy = (m_cy + int'(c[5:0])) % 60;
        end
      end
      if (cmd_valid && !full) begin
        mq.push_back({cmd_op, cmd_data});
        expq.push_back({cmd_op, cmd_data});
      end
    end
  end

  always @(negedge rst_n) begin
    mq.delete();
    expq.delete();
    last_pop = -100;
    m_op     = 2'b00;
    m_data   = 8'h00;
    m_cx     = 0;
    m_cy     = 0;
  end

  // Monitor: per-cycle state checks and scoreboard pop on each strobe rise
  logic       prev_ie = 1'b0;
  logic [9:0] sb_item;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ie = 1'b0;
    end else begin
      check("fifo_level", int'(fifo_level), mq.size());
      check("cmd_ready", int'(cmd_ready), int'(mq.size() < DEPTH));
      check("busy", int'(busy), int'(model_busy()));
      check("interrupt_enable", int'(interrupt_enable), int'(model_ie()));
      check("interrupt_in", int'(interrupt_in), int'(m_op));
      check("data_out", int'(data_out), int'(m_data));
`ifdef GPU_TX_CURSOR_SHADOW_EN
      check("cursor_x", int'(cursor_x), m_cx);
      check("cursor_y", int'(cursor_y), m_cy);
`endif
      if (interrupt_enable && !prev_ie) begin
        if (expq.size() == 0) begin
          check("sb_unexpected_strobe", 1, 0);
        end else begin
          sb_item = expq.pop_front();
          check("sb_op", int'(interrupt_in), int'(sb_item[9:8]));
          check("sb_data", int'(data_out), int'(sb_item[7:0]));
        end
      end
      prev_ie = interrupt_enable;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_ie"}, int'(interrupt_enable), 0);
    check({tag, "_op"}, int'(interrupt_in), 0);
    check({tag, "_data"}, int'(data_out), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_level"}, int'(fifo_level), 0);
    check({tag, "_ready"}, int'(cmd_ready), 1);
`ifdef GPU_TX_CURSOR_SHADOW_EN
    check({tag, "_cx"}, int'(cursor_x), 0);
    check({tag, "_cy"}, int'(cursor_y), 0);
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d);
    bit acc;
    int budget;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    acc       = 1'b0;
    budget    = 0;
    while (!acc && budget < 200) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    cmd_valid = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((model_busy() || busy) && budget < 1000) begin
      tick(1);
      budget++;
    end
    if (budget >= 1000) check("drain_timeout", 0, 1);
  endtask

  initial begin
    int budget;
    #1 rst_n = 1'b0;
    #11;
    check_reset_vals("reset_init");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single store: timing is checked cycle by cycle against the model
    send(2'b00, 8'h41);
    drain();

    // Six back-to-back offers overflow the 4-deep FIFO
    for (int i = 0; i < 6; i++) send(2'(i), 8'(8'h10 + i));
    drain();

    send(2'b01, 8'h85);
    send(2'b10, 8'h00);
    tick(3);
    send(2'b11, 8'hFF);
    drain();

    // Reset during the strobe of a DISPLAY with two commands still queued
    send(2'b10, 8'h22);
    send(2'b00, 8'h01);
    send(2'b01, 8'h02);
    budget = 0;
    while (!interrupt_enable && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("strobe_before_reset", int'(interrupt_enable), 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick(12);

    // Cursor walk from (0,0)
    for (int i = 0; i < 80; i++) send(2'b00, 8'($urandom_range(0, 255)));
    drain();
`ifdef GPU_TX_CURSOR_SHADOW_EN
    check("cursor_wrap_x", int'(cursor_x), 0);
    check("cursor_wrap_y", int'(cursor_y), 1);
`endif
    send(2'b01, 8'hCE);
    send(2'b01, 8'h85);
    drain();
`ifdef GPU_TX_CURSOR_SHADOW_EN
    check("cursor_move_x", int'(cursor_x), 3);
`endif
    send(2'b01, 8'h3B);
    drain();
`ifdef GPU_TX_CURSOR_SHADOW_EN
    check("cursor_move_y", int'(cursor_y), 0);
`endif

    // Randomized traffic with random inter-command gaps
    for (int i = 0; i < 300; i++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 8));
    end
    drain();
    tick(2);
    check("sb_leftover", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
